// File: rtl/instruction_fetch.sv
// Instruction fetch stage: drives pcNext for the ProgramCounter, issues
// single-outstanding instruction-memory reads (req/gnt, variable rvalid
// latency), buffers fetched words in a small in-order FIFO and presents
// them to decode with valid/ready. A redirect flushes buffered words and
// discards any response still in flight.
module instruction_fetch #(
  parameter int REG_BITS   = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_BITS-1:0] pc,
  output logic [REG_BITS-1:0] pcNext,
  input  logic                redirect,
  input  logic [REG_BITS-1:0] redirectTarget,
  output logic                imemReq,
  output logic [REG_BITS-1:0] imemAddr,
  input  logic                imemGnt,
  input  logic                imemRvalid,
  input  logic [31:0]         imemRdata,
  output logic                instrValid,
  output logic [31:0]         instrData,
  output logic [REG_BITS-1:0] instrPc,
  input  logic                instrReady
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

  // WAIT: a live request is outstanding. DROP: the outstanding response
  // belongs to a redirected-away path and must be discarded.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DROP = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [REG_BITS-1:0] req_pc_q, req_pc_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [31:0]         data_q [FIFO_DEPTH];
  logic [REG_BITS-1:0] epc_q  [FIFO_DEPTH];

  logic req_s;
  logic push_s;
  logic pop_s;
  logic flush_s;
  logic grant_s;

  // Circular pointer advance that also works for non-power-of-two depths.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Fetch FSM next-state, request generation and response acceptance.
  always_comb begin
    state_d  = state_q;
    req_pc_d = req_pc_q;
    req_s    = 1'b0;
    push_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        req_s = (count_q < DEPTH_C) && !redirect;
        if (req_s && imemGnt) begin
          req_pc_d = pc;
          state_d  = S_WAIT;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (imemRvalid) begin
          push_s  = !redirect;
          state_d = S_REQ;
        end else if (redirect) begin
          state_d = S_DROP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DROP: begin
        if (imemRvalid) begin
          state_d = S_REQ;
        end else begin
          state_d = S_DROP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign imemReq    = req_s;
  assign grant_s    = req_s && imemGnt;
  assign flush_s    = redirect;
  assign imemAddr   = {pc[REG_BITS-1:2], 2'b00};
  assign instrValid = (count_q != '0);
  assign instrData  = data_q[rd_ptr_q];
  assign instrPc    = epc_q[rd_ptr_q];
  // A pop during a flush cycle is seen by decode but leaves no trace here.
  assign pop_s      = instrValid && instrReady && !flush_s;

  // Next PC: redirect wins, then sequential advance on a granted fetch, else hold.
  always_comb begin
    if (redirect) begin
      pcNext = redirectTarget;
    end else if (grant_s) begin
      pcNext = pc + REG_BITS'(4);
    end else begin
      pcNext = pc;
    end
  end

  // FIFO occupancy and pointer bookkeeping, flush clears everything.
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (flush_s) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
      if (push_s) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      req_pc_q <= '0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // FIFO storage; cleared on reset so the head reads as zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_q[i] <= 32'd0;
        epc_q[i]  <= '0;
      end
    end else if (push_s) begin
      data_q[wr_ptr_q] <= imemRdata;
      epc_q[wr_ptr_q]  <= req_pc_q;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a
// randomized run, all compared against a transaction-level model built
// from the fetch rules (queue of expected instructions, outstanding flags).
module tb_instruction_fetch;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc, pcNext, redirectTarget, imemAddr, imemRdata, instrData, instrPc;
  logic        redirect, imemReq, imemGnt, imemRvalid, instrValid, instrReady;

  always #5 clk = ~clk;

  instruction_fetch #(.REG_BITS(32), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc(pc), .pcNext(pcNext),
    .redirect(redirect), .redirectTarget(redirectTarget),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemGnt(imemGnt),
    .imemRvalid(imemRvalid), .imemRdata(imemRdata),
    .instrValid(instrValid), .instrData(instrData), .instrPc(instrPc),
    .instrReady(instrReady)
  );

  int checks = 0;
  int failures = 0;

  // reference model
  bit          m_started, m_busy, m_discard;
  logic [31:0] m_reqpc;
  logic [31:0] q_data[$];
  logic [31:0] q_pc[$];
  bit          exp_req, exp_valid;
  logic [31:0] exp_pcnext, exp_addr, exp_data, exp_ipc;

  // memory responder
  bit          mem_pending;
  int          mem_cnt;
  int          mem_lat = 1;
  bit          seq_mode = 1'b1;
  bit          spur_en = 1'b0;
  logic [31:0] seq_val = 32'h13;

  task automatic model_reset();
    m_started = 1'b0; m_busy = 1'b0; m_discard = 1'b0; m_reqpc = 32'd0;
    q_data.delete(); q_pc.delete();
    mem_pending = 1'b0; mem_cnt = 0;
  endtask

  task automatic model_eval();
    exp_valid = (q_pc.size() != 0);
    exp_data  = exp_valid ? q_data[0] : 32'd0;
    exp_ipc   = exp_valid ? q_pc[0] : 32'd0;
    exp_req   = m_started && !m_busy && (q_pc.size() < DEPTH) && !redirect;
    if (redirect) exp_pcnext = redirectTarget;
    else if (exp_req && imemGnt) exp_pcnext = pc + 32'd4;
    else exp_pcnext = pc;
    exp_addr = pc & 32'hFFFF_FFFC;
  endtask

  task automatic model_update();
    bit grant, pop, push;
    if (!rst) begin
      model_reset();
      return;
    end
    grant = exp_req && imemGnt;
    pop   = exp_valid && instrReady && !redirect;
    push  = m_busy && imemRvalid && !redirect && !m_discard;
    if (m_busy && imemRvalid) begin
      m_busy = 1'b0; m_discard = 1'b0;
    end else if (m_busy && redirect) begin
      m_discard = 1'b1;
    end
    if (grant) begin
      m_busy = 1'b1; m_discard = 1'b0; m_reqpc = pc;
      mem_pending = 1'b1; mem_cnt = mem_lat;
    end
    if (redirect) begin
      q_data.delete(); q_pc.delete();
    end else begin
      if (pop) begin
        void'(q_data.pop_front()); void'(q_pc.pop_front());
      end
      if (push) begin
        q_data.push_back(imemRdata); q_pc.push_back(m_reqpc);
      end
    end
    m_started = 1'b1;
  endtask

  task automatic mem_drive();
    if (mem_pending) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imemRvalid = 1'b1;
        if (seq_mode) begin
          imemRdata = seq_val; seq_val = seq_val + 32'd1;
        end else begin
          imemRdata = $urandom;
        end
        mem_pending = 1'b0;
      end else begin
        imemRvalid = 1'b0;
      end
    end else begin
      imemRvalid = spur_en && ($urandom_range(0, 9) == 0);
      imemRdata  = $urandom;
    end
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    model_update();
    #1;
    if (rst) pc = exp_pcnext;
    mem_drive();
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic do_reset(input logic [31:0] pc0);
    rst = 1'b0; redirect = 1'b0; redirectTarget = 32'd0; imemGnt = 1'b0;
    imemRvalid = 1'b0; imemRdata = 32'd0; instrReady = 1'b0; pc = pc0;
    seq_val = 32'h13;
    model_reset();
    tick();
    tick();
    rst = 1'b1;
    tick();  // IDLE cycle
  endtask

  task automatic test_reset();
    rst = 1'b0; redirect = 1'b0; redirectTarget = 32'd0; imemGnt = 1'b0;
    imemRvalid = 1'b0; imemRdata = 32'd0; instrReady = 1'b0; pc = 32'h40;
    model_reset();
    tick();
    settle();
    checks++; if (imemReq !== 1'b0) begin failures++; $display("FAIL reset_req: got %b want 0", imemReq); end
    checks++; if (instrValid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", instrValid); end
    checks++; if (instrData !== 32'd0) begin failures++; $display("FAIL reset_data: got %h want 0", instrData); end
    checks++; if (instrPc !== 32'd0) begin failures++; $display("FAIL reset_pc: got %h want 0", instrPc); end
    rst = 1'b1;
    settle();
    checks++; if (imemReq !== 1'b0) begin failures++; $display("FAIL idle_req: got %b want 0", imemReq); end
    tick();
    settle();
    checks++; if (imemReq !== 1'b1) begin failures++; $display("FAIL first_req: got %b want 1", imemReq); end
    checks++; if (imemAddr !== 32'h40) begin failures++; $display("FAIL first_addr: got %h want 00000040", imemAddr); end
  endtask

  task automatic test_stream();
    int seen = 0;
    seq_val = 32'h13; seq_mode = 1'b1; mem_lat = 1; imemGnt = 1'b1; instrReady = 1'b1;
    for (int c = 0; c < 14; c++) begin
      settle();
      checks++; if (imemReq !== exp_req) begin failures++; $display("FAIL stream_req c%0d: got %b want %b", c, imemReq, exp_req); end
      checks++; if (pcNext !== exp_pcnext) begin failures++; $display("FAIL stream_pcnext c%0d: got %h want %h", c, pcNext, exp_pcnext); end
      checks++; if (instrValid !== exp_valid) begin failures++; $display("FAIL stream_valid c%0d: got %b want %b", c, instrValid, exp_valid); end
      if (exp_valid) begin
        checks++; if (instrPc !== 32'h40 + 32'(4 * seen)) begin failures++; $display("FAIL stream_pc: got %h want %h", instrPc, 32'h40 + 32'(4 * seen)); end
        checks++; if (instrData !== 32'h13 + 32'(seen)) begin failures++; $display("FAIL stream_data: got %h want %h", instrData, 32'h13 + 32'(seen)); end
        seen++;
      end
      tick();
    end
    checks++; if (seen != 6) begin failures++; $display("FAIL stream_count: got %0d want 6", seen); end
  endtask

  task automatic test_backpressure();
    do_reset(32'h40);
    mem_lat = 1; imemGnt = 1'b1; instrReady = 1'b0;
    for (int c = 0; c < 8; c++) begin
      settle();
      checks++; if (imemReq !== exp_req) begin failures++; $display("FAIL bp_req c%0d: got %b want %b", c, imemReq, exp_req); end
      checks++; if (pcNext !== exp_pcnext) begin failures++; $display("FAIL bp_pcnext c%0d: got %h want %h", c, pcNext, exp_pcnext); end
      tick();
    end
    settle();
    checks++; if (imemReq !== 1'b0) begin failures++; $display("FAIL bp_full_req: got %b want 0", imemReq); end
    checks++; if (pcNext !== 32'h48) begin failures++; $display("FAIL bp_hold_pc: got %h want 00000048", pcNext); end
    checks++; if (instrPc !== 32'h40 || instrValid !== 1'b1) begin failures++; $display("FAIL bp_head0: got %h/%b want 00000040/1", instrPc, instrValid); end
    checks++; if (instrData !== 32'h13) begin failures++; $display("FAIL bp_data0: got %h want 00000013", instrData); end
    instrReady = 1'b1;
    tick();
    settle();
    checks++; if (instrPc !== 32'h44 || instrData !== 32'h14) begin failures++; $display("FAIL bp_head1: got %h/%h want 00000044/00000014", instrPc, instrData); end
    checks++; if (imemReq !== 1'b1 || imemAddr !== 32'h48) begin failures++; $display("FAIL bp_resume: got %b/%h want 1/00000048", imemReq, imemAddr); end
    tick();
  endtask

  task automatic test_redirect_wait();
    do_reset(32'h40);
    mem_lat = 3; imemGnt = 1'b1; instrReady = 1'b1;
    settle();
    checks++; if (imemReq !== 1'b1) begin failures++; $display("FAIL rw_req0: got %b want 1", imemReq); end
    tick();
    mem_lat = 1;
    redirect = 1'b1; redirectTarget = 32'h100;
    settle();
    checks++; if (pcNext !== 32'h100) begin failures++; $display("FAIL rw_pcnext: got %h want 00000100", pcNext); end
    checks++; if (imemReq !== 1'b0) begin failures++; $display("FAIL rw_req_wait: got %b want 0", imemReq); end
    tick();
    redirect = 1'b0;
    settle();
    checks++; if (imemReq !== 1'b0) begin failures++; $display("FAIL rw_req_drop: got %b want 0", imemReq); end
    tick();
    settle();
    checks++; if (instrValid !== 1'b0 || imemReq !== 1'b0) begin failures++; $display("FAIL rw_rvalid_cycle: got %b/%b want 0/0", instrValid, imemReq); end
    tick();
    settle();
    checks++; if (instrValid !== 1'b0) begin failures++; $display("FAIL rw_dropped: got %b want 0", instrValid); end
    checks++; if (imemReq !== 1'b1 || imemAddr !== 32'h100) begin failures++; $display("FAIL rw_refetch: got %b/%h want 1/00000100", imemReq, imemAddr); end
    tick();
    tick();
    settle();
    checks++; if (instrValid !== 1'b1 || instrPc !== 32'h100 || instrData !== 32'h14) begin failures++; $display("FAIL rw_newhead: got %b/%h/%h want 1/00000100/00000014", instrValid, instrPc, instrData); end
    tick();
  endtask

  task automatic test_redirect_same();
    do_reset(32'h40);
    mem_lat = 1; imemGnt = 1'b1; instrReady = 1'b0;
    tick();
    tick();
    settle();
    checks++; if (instrValid !== 1'b1 || instrPc !== 32'h40 || imemReq !== 1'b1) begin failures++; $display("FAIL rs_pre: got %b/%h/%b want 1/00000040/1", instrValid, instrPc, imemReq); end
    tick();
    redirect = 1'b1; redirectTarget = 32'h100;
    settle();
    checks++; if (pcNext !== 32'h100) begin failures++; $display("FAIL rs_pcnext: got %h want 00000100", pcNext); end
    checks++; if (instrValid !== 1'b1) begin failures++; $display("FAIL rs_one_entry: got %b want 1", instrValid); end
    tick();
    redirect = 1'b0;
    settle();
    checks++; if (instrValid !== 1'b0) begin failures++; $display("FAIL rs_flushed: got %b want 0", instrValid); end
    checks++; if (imemReq !== 1'b1 || imemAddr !== 32'h100) begin failures++; $display("FAIL rs_refetch: got %b/%h want 1/00000100", imemReq, imemAddr); end
    instrReady = 1'b1;
    tick();
    tick();
    settle();
    checks++; if (instrValid !== 1'b1 || instrPc !== 32'h100 || instrData !== 32'h15) begin failures++; $display("FAIL rs_newhead: got %b/%h/%h want 1/00000100/00000015", instrValid, instrPc, instrData); end
    tick();
  endtask

  task automatic test_wrap_reset();
    do_reset(32'hFFFF_FFFC);
    mem_lat = 1; imemGnt = 1'b1; instrReady = 1'b0;
    settle();
    checks++; if (imemReq !== 1'b1 || pcNext !== 32'd0) begin failures++; $display("FAIL wrap_pcnext: got %b/%h want 1/00000000", imemReq, pcNext); end
    tick();
    mem_lat = 3;
    tick();
    settle();
    checks++; if (instrValid !== 1'b1 || instrPc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_head: got %b/%h want 1/fffffffc", instrValid, instrPc); end
    checks++; if (imemReq !== 1'b1 || imemAddr !== 32'd0) begin failures++; $display("FAIL wrap_addr: got %b/%h want 1/00000000", imemReq, imemAddr); end
    tick();
    settle();
    rst = 1'b0;
    #1;
    checks++; if (instrValid !== 1'b0 || imemReq !== 1'b0) begin failures++; $display("FAIL async_rst_ctl: got %b/%b want 0/0", instrValid, imemReq); end
    checks++; if (instrData !== 32'd0 || instrPc !== 32'd0) begin failures++; $display("FAIL async_rst_data: got %h/%h want 0/0", instrData, instrPc); end
    pc = 32'h40; mem_lat = 1;
    tick();
    tick();
    rst = 1'b1;
    settle();
    checks++; if (imemReq !== 1'b0) begin failures++; $display("FAIL rerst_idle: got %b want 0", imemReq); end
    tick();
    settle();
    checks++; if (imemReq !== 1'b1 || imemAddr !== 32'h40) begin failures++; $display("FAIL rerst_req: got %b/%h want 1/00000040", imemReq, imemAddr); end
    tick();
    tick();
    settle();
    checks++; if (instrValid !== 1'b1 || instrPc !== 32'h40 || instrData !== exp_data) begin failures++; $display("FAIL rerst_head: got %b/%h/%h want 1/00000040/%h", instrValid, instrPc, instrData, exp_data); end
    tick();
  endtask

  task automatic test_random();
    do_reset({$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
    seq_mode = 1'b0; spur_en = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      imemGnt        = ($urandom_range(0, 1) == 1);
      instrReady     = ($urandom_range(0, 9) < 7);
      redirect       = ($urandom_range(0, 11) == 0);
      redirectTarget = $urandom;
      mem_lat        = $urandom_range(1, 4);
      settle();
      checks++; if (imemReq !== exp_req) begin failures++; $display("FAIL rnd_req c%0d: got %b want %b", c, imemReq, exp_req); end
      checks++; if (imemAddr !== exp_addr) begin failures++; $display("FAIL rnd_addr c%0d: got %h want %h", c, imemAddr, exp_addr); end
      checks++; if (pcNext !== exp_pcnext) begin failures++; $display("FAIL rnd_pcnext c%0d: got %h want %h", c, pcNext, exp_pcnext); end
      checks++; if (instrValid !== exp_valid) begin failures++; $display("FAIL rnd_valid c%0d: got %b want %b", c, instrValid, exp_valid); end
      if (exp_valid) begin
        checks++; if (instrData !== exp_data) begin failures++; $display("FAIL rnd_data c%0d: got %h want %h", c, instrData, exp_data); end
        checks++; if (instrPc !== exp_ipc) begin failures++; $display("FAIL rnd_ipc c%0d: got %h want %h", c, instrPc, exp_ipc); end
      end
      tick();
    end
    redirect = 1'b0; spur_en = 1'b0; seq_mode = 1'b1;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_same();
    test_wrap_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch stage between the ProgramCounter register and decode. It consumes `pc` and computes `pcNext`, which the ProgramCounter registers every clock. It issues single-outstanding instruction-memory reads with a req/gnt handshake and variable response latency. Fetched words are buffered in a small FIFO and presented to decode with a valid/ready handshake; a redirect (branch/jump) flushes in-flight and buffered instructions.

Parameters:
REG_BITS, 32, width of PC and address buses.
FIFO_DEPTH, 2, number of fetched-instruction entries (≥1).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-low reset.
pc  input  REG_BITS  current PC from ProgramCounter.
pcNext  output  REG_BITS  next PC to ProgramCounter (combinational).
redirect  input  1  branch/jump taken; flush and retarget.
redirectTarget  input  REG_BITS  new PC when redirect=1.
imemReq  output  1  read request.
imemAddr  output  REG_BITS  read address.
imemGnt  input  1  request accepted this cycle.
imemRvalid  input  1  read data valid.
imemRdata  input  32  instruction word.
instrValid  output  1  FIFO head valid.
instrData  output  32  FIFO head instruction.
instrPc  output  REG_BITS  PC of FIFO head.
instrReady  input  1  decode accepts head.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, FIFO count=0, imemReq=0, instrValid=0, instrData=0, instrPc=0, internal reqPc=0. No state changes while reset is asserted.
- imemAddr = {pc[REG_BITS-1:2], 2'b00}; low PC bits are ignored.
- pcNext, priority order: redirect=1 → redirectTarget; else imemReq&&imemGnt → pc+4, modulo 2^REG_BITS (0xFFFFFFFC → 0); else pc.
- FSM states and transitions:
  - IDLE: imemReq=0. Always → REQ. This gives one cycle after reset release for pc to settle.
  - REQ: imemReq = (count<FIFO_DEPTH) && !redirect.
    - On imemReq&&imemGnt: latch reqPc=pc, → WAIT.
    - Redirect → stay in REQ and flush the FIFO.
  - WAIT: imemReq=0.
    - imemRvalid && !redirect: push {imemRdata, reqPc}, → REQ.
    - redirect && imemRvalid in the same cycle: discard the response, flush, → REQ.
    - redirect && !imemRvalid: flush, → DROP.
  - DROP: imemReq=0. On imemRvalid: discard the response, → REQ. Redirect here flushes again and stays in DROP.
- Request-side rules:
  - At most one request outstanding.
  - imemGnt is ignored when imemReq=0.
  - imemRvalid is ignored in IDLE and REQ.
- FIFO:
  - Registered, in-order.
  - Pop when instrValid && instrReady. Push and pop in the same cycle are both performed.
  - Requests are issued only when count<FIFO_DEPTH and nothing is outstanding, so a push never overflows.
  - Flush sets count=0 at the clock edge, so instrValid=0 the following cycle. A pop in the flush cycle is still taken by decode but has no further effect.
- Latency:
  - gnt at cycle t, rvalid at t+k (k≥0 after gnt, k≥1 cycle) → instrValid at t+k+1.
  - Peak throughput: 1 instruction per 2 cycles.
- Stall: with no grant and no redirect, pcNext=pc and the PC holds.

Test Plan:
- Reset: rst=0 with pc=0x40 → imemReq=0, instrValid=0, instrData=0, instrPc=0. Release rst → one IDLE cycle, then imemReq=1, imemAddr=0x40.
- Stream: gnt same cycle as req, rvalid next cycle, rdata=0x00000013+n, instrReady=1 → instrPc sequence 0x40,0x44,0x48… with matching data and pcNext=pc+4 on each grant cycle.
- Backpressure: FIFO_DEPTH=2, instrReady=0 → after 2 entries imemReq=0 and pcNext==pc. Set instrReady=1 → pops 0x40 then 0x44 in order, then fetching resumes at 0x48.
- Redirect in WAIT: redirect=1, target 0x100, rvalid 3 cycles later → that response is dropped, instrValid=0, next imemAddr=0x100, next instrPc=0x100.
- Redirect and rvalid in the same cycle, with FIFO holding one entry → FIFO empty next cycle, stale word never appears, pcNext=0x100.
- Wrap and mid-operation reset: pc=0xFFFFFFFC granted → pcNext=0x0. Assert rst during WAIT → outputs zero immediately (asynchronous), and after release the bench restarts from IDLE.
